bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
//
// PURPOSE
// - Consumes the 16-bit packed-BCD word from the binary-to-BCD converter and drives a
//   4-digit common-anode seven-segment display by time-multiplexing its digits.
// - The new value is accepted through a valid/ready handshake into a pending register.
// - The pending value is promoted to the displayed value only at a frame boundary, so the
//   display never shows a mix of old and new digits.
// - Sits between the converter and the board display pins.
//
// PARAMETERS
// - DIV_COUNT  50000  clocks per digit slot (refresh tick period); legal range >= 2
// - DIV_WIDTH  16     prescaler counter width; must satisfy 2**DIV_WIDTH >= DIV_COUNT
//
// PORTS
// - clk       in   1   system clock, all state on rising edge
// - reset_n   in   1   asynchronous active-low reset
// - in_bcd    in   16  packed BCD, [15:12]=thousands ... [3:0]=units
// - in_valid  in   1   in_bcd is valid this cycle
// - in_ready  out  1   block can accept in_bcd (registered)
// - seg       out  7   {g,f,e,d,c,b,a}, active low (registered)
// - an        out  4   digit enables, active low, an[0]=units (registered)
//
// BEHAVIOUR
// - Reset values (async assert, sync release):
//   - prescaler=0, digit index=0, pending=0, pend_val=0, disp_val=0
//   - in_ready=1, an=4'b1111, seg=7'h7F
// - Prescaler counts 0..DIV_COUNT-1 and wraps. tick = (prescaler==DIV_COUNT-1).
//   - First tick occurs DIV_COUNT cycles after reset release.
// - On each tick edge, in one clock edge:
//   - digit <= (digit+1) mod 4
//   - an <= one-hot-low of the new digit
//   - seg <= decode of that digit's nibble
//   - Index 3 wraps to 0.
//   - At the first tick after reset: digit goes to 1, an=4'b1101.
// - Between ticks, an and seg hold. No blanking gap between digits.
// - Handshake:
//   - Transfer occurs when in_valid && in_ready.
//     - Edge effect: pend_val<=in_bcd, pending<=1, in_ready<=0 (low from next cycle).
//   - in_valid while in_ready=0 is ignored; no stall.
//   - No combinational path from in_valid to in_ready.
// - Frame boundary = tick edge with digit==3 (wrap to 0):
//   - If pending=1 at that edge: disp_val<=pend_val, pending<=0, in_ready<=1.
//   - The seg value for digit 0 on that same edge uses the NEW value (pend_val).
// - Simultaneous accept and frame boundary:
//   - Only possible with pending=0.
//   - The value is captured into pending and shown at the NEXT boundary; no bypass.
// - Decode, active low:
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
//   - Nibbles A-F show a dash (g only) = 7'h3F.
// - Reset mid-frame forces reset values immediately and discards pending data.
//
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined:
//   - Digits 3..1 show seg=7'h7F when the nibble and every more-significant nibble are 0.
//   - The anode is still driven; the digit is simply dark.
//   - Digit 0 is never blanked.
//   - An invalid nibble (A-F) is never blanked and also stops blanking below it.
// - LEADING_ZERO_BLANK_EN undefined: all four digits are always decoded.
// - No effect on timing or handshake.
//
// TESTING  (bench uses DIV_COUNT=4, DIV_WIDTH=2)
// 1. Reset:
//    - hold reset_n=0 -> an=F, seg=7F, in_ready=1
//    - release -> an stays F for 4 clocks, then an=D, seg=40
// 2. Accept 16'h1234 at cycle 1:
//    - in_ready=0 from cycle 2
//    - digits show 0 until the wrap tick, then an=E, seg=19 ('4')
//    - next ticks: 30, 24, 79
//    - in_ready=1 after the wrap
// 3. Back-pressure:
//    - offer 16'h5678 while pending=1 -> ignored
//    - after the wrap, offer 16'h9999 -> displayed one frame later; 5678 never appears
// 4. Invalid digit:
//    - accept 16'h00A0 -> digit 1 shows seg=3F, others seg=40
//    - with LEADING_ZERO_BLANK_EN: digits 3,2 show 7F, digit 1 shows 3F, digit 0 shows 40
// 5. Blanking (LEADING_ZERO_BLANK_EN):
//    - 16'h0000 -> digits 3..1 = 7F, digit 0 = 40
//    - 16'h0105 -> digit 3 = 7F, digit 2 = 79, digit 1 = 40, digit 0 = 12
// 6. Reset mid-frame:
//    - accept 16'h4321, assert reset_n=0 before the wrap -> immediate reset values
//    - after release, display shows 0000 and in_ready=1

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - packed-BCD valid/ready input channel for the display scanner
interface bcd_display_scanner_if;
    logic [15:0] in_bcd;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_bcd,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_bcd,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - 4-digit multiplexed seven-segment scanner, optional LEADING_ZERO_BLANK_EN
module bcd_display_scanner #(
    parameter int DIV_COUNT = 50000,
    parameter int DIV_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bcd_display_scanner_if.slave   bus,
    output logic [6:0]             seg,
    output logic [3:0]             an
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] prescaler;
    logic [1:0]           digit;
    logic                 pending;
    logic [15:0]          pend_val;
    logic [15:0]          disp_val;
    logic                 in_ready_q;

    logic                 tick;
    logic                 frame_wrap;
    logic                 promote;
    logic                 accept;
    logic [1:0]           next_digit;
    logic [15:0]          frame_val;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [6:0] decode_nibble(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    // Segment pattern for one digit position of a packed BCD word.
    function automatic logic [6:0] digit_segments(input logic [15:0] value, input logic [1:0] pos);
        logic [3:0] nib;
        logic       dark;
        nib  = value[{pos, 2'b00} +: 4];
        dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is dark only when it and everything above it are zero; a
        // non-decimal nibble is nonzero, so it naturally stops the blanking.
        case (pos)
            2'd3:    dark = (value[15:12] == 4'd0);
            2'd2:    dark = (value[15:8] == 8'd0);
            2'd1:    dark = (value[15:4] == 12'd0);
            default: dark = 1'b0;
        endcase
`endif
        return dark ? 7'h7F : decode_nibble(nib);
    endfunction

    assign tick       = (prescaler == DIV_LAST);
    assign frame_wrap = tick && (digit == 2'd3);
    assign promote    = frame_wrap && pending;
    assign accept     = bus.in_valid && in_ready_q;
    assign next_digit = digit + 2'd1;
    // On the wrap edge digit 0 must already show the promoted value.
    assign frame_val  = promote ? pend_val : disp_val;
    assign bus.in_ready = in_ready_q;

    // Refresh prescaler: one tick every DIV_COUNT clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + DIV_WIDTH'(1);
        end
    end

    // Digit scan: advance the digit and drive its anode and segments on each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit <= 2'd0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
        end else if (tick) begin
            digit <= next_digit;
            an    <= ~(4'b0001 << next_digit);
            seg   <= digit_segments(frame_val, next_digit);
        end
    end

    // Handshake and frame-aligned promotion of the pending value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            pend_val   <= 16'h0000;
            disp_val   <= 16'h0000;
            in_ready_q <= 1'b1;
        end else if (promote) begin
            // in_ready is low whenever pending is set, so no accept can collide here.
            disp_val   <= pend_val;
            pending    <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (accept) begin
            // An accept on a wrap edge with nothing pending waits for the next frame.
            pend_val   <= bus.in_bcd;
            pending    <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(.DIV_COUNT(4), .DIV_WIDTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int          m_cyc;
    int          m_ticks;
    int          m_shown;
    bit          m_pend;
    int          m_pend_val;

    int          mm;
    logic [6:0]  got [4];
    logic [6:0]  bad_seg;
    logic [3:0]  bad_an;
    logic [6:0]  bad_exp_seg;
    logic [3:0]  bad_exp_an;

    function automatic logic [6:0] glyph(input int nib);
        case (nib)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [6:0] model_seg_of(input int val, input int pos);
        int upper;
        upper = val >> (4 * pos);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && upper == 0) return 7'h7F;
`endif
        return glyph(upper % 16);
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] e;
        e = 4'hF;
        if (m_ticks > 0) e[m_ticks % 4] = 1'b0;
        return e;
    endfunction

    function automatic logic [6:0] exp_seg();
        if (m_ticks == 0) return 7'h7F;
        return model_seg_of(m_shown, m_ticks % 4);
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_ticks = 0; m_shown = 0; m_pend = 0; m_pend_val = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic v, input logic [15:0] d);
        bit acc;
        bus.in_valid = v;
        bus.in_bcd   = d;
        @(posedge clk);
        acc = v && !m_pend;
        if (m_cyc % 4 == 3) begin
            m_ticks++;
            if (m_ticks % 4 == 0 && m_pend) begin
                m_shown = m_pend_val;
                m_pend  = 0;
            end
        end
        if (acc) begin
            m_pend = 1;
            m_pend_val = int'(d);
        end
        m_cyc++;
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Runs n cycles, tallies model disagreements into mm and records the last seg per digit.
    task automatic run_cycles(input int n, input logic v, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            step(v, d);
            if (an !== exp_an() || seg !== exp_seg() || bus.in_ready !== !m_pend) begin
                mm++;
                bad_an = an; bad_seg = seg; bad_exp_an = exp_an(); bad_exp_seg = exp_seg();
            end
            for (int k = 0; k < 4; k++) if (an[k] === 1'b0) got[k] = seg;
        end
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'h0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        mm = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bcd = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (an !== 4'hF) $display("FAIL reset_an: got %h expected f", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h expected 7f", seg); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.in_ready); else passed++;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0);
            total++; if (an !== 4'hF) $display("FAIL reset_hold_an cycle %0d: got %h expected f", i + 1, an); else passed++;
        end
        step(1'b0, 16'h0);
        total++; if (an !== 4'hD) $display("FAIL first_tick_an: got %h expected d", an); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL first_tick_seg: got %h expected 40", seg); else passed++;
    endtask

    task automatic test_accept();
        logic [3:0] seq_an [$];
        logic [6:0] seq_seg [$];
        logic [3:0] want_an  [7] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] want_seg [7] = '{7'h40, 7'h40, 7'h40, 7'h19, 7'h30, 7'h24, 7'h79};
        logic [3:0] prev_an;
        apply_reset();
        step(1'b1, 16'h1234);
        step(1'b0, 16'h0);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL accept_ready_low: got %b expected 0", bus.in_ready); else passed++;
        prev_an = an;
        for (int i = 0; i < 29; i++) begin
            run_cycles(1, 1'b0, 16'h0);
            if (an !== prev_an) begin
                seq_an.push_back(an);
                seq_seg.push_back(seg);
            end
            prev_an = an;
        end
        total++; if (seq_an.size() < 7) $display("FAIL accept_tick_count: got %0d expected 7", seq_an.size()); else passed++;
        for (int i = 0; i < 7 && i < seq_an.size(); i++) begin
            total++;
            if (seq_an[i] !== want_an[i] || seq_seg[i] !== want_seg[i])
                $display("FAIL accept_seq[%0d]: got an=%h seg=%h expected an=%h seg=%h", i, seq_an[i], seq_seg[i], want_an[i], want_seg[i]);
            else passed++;
        end
        total++; if (bus.in_ready !== 1'b1) $display("FAIL accept_ready_back: got %b expected 1", bus.in_ready); else passed++;
        total++; if (mm !== 0) $display("FAIL accept_model: %0d cycles off, last got an=%h seg=%h expected an=%h seg=%h", mm, bad_an, bad_seg, bad_exp_an, bad_exp_seg); else passed++;
    endtask

    task automatic test_back_to_back();
        int seen_old;
        apply_reset();
        step(1'b1, 16'h1234);
        run_cycles(6, 1'b1, 16'h5678);
        for (int i = 0; i < 40 && m_pend; i++) run_cycles(1, 1'b0, 16'h0);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_after_wrap: got %b expected 1", bus.in_ready); else passed++;
        run_cycles(1, 1'b1, 16'h9999);
        seen_old = 0;
        for (int i = 0; i < 36; i++) begin
            run_cycles(1, 1'b0, 16'h0);
            if (seg === 7'h12 || seg === 7'h02 || seg === 7'h78) seen_old++;
        end
        total++; if (seen_old !== 0) $display("FAIL b2b_ignored_value_shown: got %0d cycles expected 0", seen_old); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (got[k] !== 7'h10) $display("FAIL b2b_digit%0d: got %h expected 10", k, got[k]); else passed++;
        end
        total++; if (mm !== 0) $display("FAIL b2b_model: %0d cycles off, last got an=%h seg=%h expected an=%h seg=%h", mm, bad_an, bad_seg, bad_exp_an, bad_exp_seg); else passed++;
    endtask

    task automatic check_frame(input string name, input logic [15:0] val, input logic [6:0] w3,
                               input logic [6:0] w2, input logic [6:0] w1, input logic [6:0] w0);
        logic [6:0] want [4];
        want = '{w0, w1, w2, w3};
        apply_reset();
        step(1'b1, val);
        run_cycles(36, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got[k] !== want[k]) $display("FAIL %s_digit%0d: got %h expected %h", name, k, got[k], want[k]);
            else passed++;
        end
        total++; if (mm !== 0) $display("FAIL %s_model: %0d cycles off, last got an=%h seg=%h expected an=%h seg=%h", name, mm, bad_an, bad_seg, bad_exp_an, bad_exp_seg); else passed++;
    endtask

    task automatic test_invalid_digit();
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("invalid", 16'h00A0, 7'h7F, 7'h7F, 7'h3F, 7'h40);
`else
        check_frame("invalid", 16'h00A0, 7'h40, 7'h40, 7'h3F, 7'h40);
`endif
    endtask

    task automatic test_blanking();
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("zero", 16'h0000, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        check_frame("blank0105", 16'h0105, 7'h7F, 7'h79, 7'h40, 7'h12);
`else
        check_frame("zero", 16'h0000, 7'h40, 7'h40, 7'h40, 7'h40);
        check_frame("blank0105", 16'h0105, 7'h40, 7'h79, 7'h40, 7'h12);
`endif
    endtask

    task automatic test_random();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(1, 0) == 1)
                for (int k = 0; k < 4; k++) d[4*k +: 4] = 4'($urandom_range(9, 0));
            else
                d = 16'($urandom);
            if ($urandom_range(3, 0) == 0 && $urandom_range(1, 0) == 1) d[15:8] = 8'h00;
            run_cycles(1, ($urandom_range(3, 0) == 0), d);
        end
        total++; if (mm !== 0) $display("FAIL random_model: %0d cycles off, last got an=%h seg=%h expected an=%h seg=%h", mm, bad_an, bad_seg, bad_exp_an, bad_exp_seg); else passed++;
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        step(1'b1, 16'h4321);
        run_cycles(6, 1'b0, 16'h0);
        reset_n = 1'b0;
        #1;
        total++; if (an !== 4'hF) $display("FAIL midreset_an: got %h expected f", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL midreset_seg: got %h expected 7f", seg); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", bus.in_ready); else passed++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        mm = 0;
        run_cycles(40, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            total++; if (got[k] !== ((k == 0) ? 7'h40 : 7'h7F)) $display("FAIL midreset_digit%0d: got %h expected %h", k, got[k], (k == 0) ? 7'h40 : 7'h7F); else passed++;
`else
            total++; if (got[k] !== 7'h40) $display("FAIL midreset_digit%0d: got %h expected 40", k, got[k]); else passed++;
`endif
        end
        total++; if (bus.in_ready !== 1'b1) $display("FAIL midreset_ready_after: got %b expected 1", bus.in_ready); else passed++;
        total++; if (mm !== 0) $display("FAIL midreset_model: %0d cycles off, last got an=%h seg=%h expected an=%h seg=%h", mm, bad_an, bad_seg, bad_exp_an, bad_exp_seg); else passed++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'h0;
        model_reset();
        mm = 0;
        test_reset();
        test_accept();
        test_back_to_back();
        test_invalid_digit();
        test_blanking();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
